countdown_timer: RTL

- User-settable MM:SS countdown that generates the `ring` alarm level consumed by the downstream countdown LED flasher.
- Accepts load/start/pause/clear commands from the key/menu logic and decrements once per second using an internal prescaler on the system clock.
- Exposes the remaining time for the display path.
- On reaching 00:00, holds `ring` high until it is cleared, reloaded, or the ring-hold period expires.

---
 rtl/countdown_timer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS countdown with a per-second prescaler and a timed ring alarm
module countdown_timer #(
  parameter int TICK_DIV  = 5000000,
  parameter int RING_SECS = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [6:0] set_min,
  input  logic [5:0] set_sec,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic       ring,
  output logic       running,
  output logic       paused,
  output logic [6:0] rem_min,
  output logic [5:0] rem_sec,
  output logic       sec_tick
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int RW = RING_SECS < 2 ? 1 : $clog2(RING_SECS + 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, RING} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d, presc_nx;
  logic [RW-1:0] rcnt_q, rcnt_d, rcnt_nx;
  logic [6:0] min_q, min_d, dec_min, lmin;
  logic [5:0] sec_q, sec_d, dec_sec, lsec;
  logic tick_q, tick_d, ring_q, ring_d, running_q, running_d, paused_q, paused_d, wrap;
  always_comb begin
    wrap = presc_q == PW'(TICK_DIV - 1);
    presc_nx = wrap ? '0 : presc_q + PW'(1);
    rcnt_nx = rcnt_q + RW'(1);
    dec_sec = sec_q == 6'd0 ? 6'd59 : sec_q - 6'd1;
    dec_min = sec_q == 6'd0 ? min_q - 7'd1 : min_q;
    lmin = set_min > 7'd99 ? 7'd99 : set_min;
    lsec = set_sec > 6'd59 ? 6'd59 : set_sec;
    state_d = state_q;
    presc_d = presc_q;
    rcnt_d = rcnt_q;
    min_d = min_q;
    sec_d = sec_q;
    tick_d = 1'b0;
    // a load in RUN only lands on the terminal-tick cycle, where it must beat the ring
    if (clear) begin
      state_d = IDLE;
      presc_d = '0;
      rcnt_d = '0;
      min_d = '0;
      sec_d = '0;
    end else if (load && (state_q != RUN || wrap)) begin
      state_d = IDLE;
      presc_d = '0;
      rcnt_d = '0;
      min_d = lmin;
      sec_d = lsec;
    end else begin
      case (state_q)
        IDLE: if (start && (min_q != 7'd0 || sec_q != 6'd0)) begin
          state_d = RUN;
          presc_d = '0;
        end
        RUN: if (pause) begin
          state_d = PAUSE;
          presc_d = wrap ? presc_q : presc_nx;
        end else begin
          presc_d = presc_nx;
          if (wrap) begin
            min_d = dec_min;
            sec_d = dec_sec;
            tick_d = 1'b1;
            state_d = dec_min == 7'd0 && dec_sec == 6'd0 ? RING : RUN;
          end
        end
        PAUSE: if (start) state_d = RUN;
        RING: begin
          presc_d = presc_nx;
          if (wrap) begin
            // the expiring second returns to IDLE, which never shows sec_tick
            if (RING_SECS != 0 && rcnt_nx == RW'(RING_SECS)) begin
              state_d = IDLE;
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_nx;
              tick_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    ring_d = state_d == RING;
    running_d = state_d == RUN;
    paused_d = state_d == PAUSE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      rcnt_q <= '0;
      min_q <= '0;
      sec_q <= '0;
      tick_q <= 1'b0;
      ring_q <= 1'b0;
      running_q <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      rcnt_q <= rcnt_d;
      min_q <= min_d;
      sec_q <= sec_d;
      tick_q <= tick_d;
      ring_q <= ring_d;
      running_q <= running_d;
      paused_q <= paused_d;
    end
  assign ring = ring_q;
  assign running = running_q;
  assign paused = paused_q;
  assign rem_min = min_q;
  assign rem_sec = sec_q;
  assign sec_tick = tick_q;
endmodule
